cmd_ring_bram: RTL and testbench

//  Parametrised command-ring BRAM between the host BRAM slave port and the graphics command decoder.

---
 rtl/cmd_ring_bram.sv | 188 ++++++++++++++++++
 tb/tb_cmd_ring_bram.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_ring_bram.sv
// Command-ring BRAM: host byte-enabled R/W port plus internal fetch engine that assembles
// header + operand commands onto a valid/ready handshake. Optional macro: CMD_STATS_EN.
module cmd_ring_bram #(
    parameter int ADDR_W  = 10,
    parameter int NUM_OPS = 4
) (
    input  logic                   BRAM_clk,
    input  logic                   BRAM_rst_n,
    input  logic                   BRAM_en,
    input  logic [0:3]             BRAM_wen,
    input  logic [0:31]            BRAM_addr,
    input  logic [0:31]            BRAM_dout,
    output logic [0:31]            BRAM_din,
    input  logic [ADDR_W-1:0]      cmd_wr_ptr,
    output logic [ADDR_W-1:0]      cmd_rd_ptr,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic [31:0]            cmd_hdr,
    output logic [2:0]             cmd_nops,
    output logic [32*NUM_OPS-1:0]  cmd_ops,
    output logic                   cmd_err,
    output logic [15:0]            cmd_count
);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_WAIT, S_OPS, S_VALID} state_t;

    localparam int         DEPTH = 2**ADDR_W;
    localparam logic [2:0] MAX_N = 3'(NUM_OPS);

    logic [31:0]           r_mem [DEPTH];
    logic [31:0]           r_din;
    logic [31:0]           r_b_data;
    logic [31:0]           w_wdata;
    logic [ADDR_W-1:0]     w_host_idx;
    logic [ADDR_W-1:0]     w_fetch_addr;
    logic [ADDR_W-1:0]     w_fetch_off;
    logic [ADDR_W-1:0]     w_avail;
    logic                  w_unused_addr;

    state_t                r_state, w_next;
    logic [ADDR_W-1:0]     r_rd_ptr;
    logic [31:0]           r_hdr;
    logic [2:0]            r_nops;
    logic [2:0]            r_k;
    logic [32*NUM_OPS-1:0] r_ops;
    logic                  r_err;

    logic [2:0]            w_hdr_cnt;
    logic                  w_over;
    logic [2:0]            w_dec_n;
    logic [2:0]            w_chk_n;
    logic                  w_enough;
    logic                  w_last_op;
    logic                  w_accept;

    // Big-endian bus numbering: bit 0 is the MSB, so numeric value is preserved.
    assign w_host_idx    = BRAM_addr[30-ADDR_W:29];
    assign w_wdata       = BRAM_dout;
    assign w_unused_addr = ^{BRAM_addr[0:29-ADDR_W], BRAM_addr[30:31]};

    always_ff @(posedge BRAM_clk) begin
        // NOTE: the array has no reset so it maps onto block RAM; contents survive rst_n.
        for (int b = 0; b < 4; b++) begin
            if (BRAM_en && BRAM_wen[b])
                r_mem[w_host_idx][31-8*b -: 8] <= w_wdata[31-8*b -: 8];
        end
        r_b_data <= r_mem[w_fetch_addr];
    end

    // Read-first on both ports: a same-edge write is only visible on the following read.
    always_ff @(posedge BRAM_clk or negedge BRAM_rst_n) begin
        if (!BRAM_rst_n)
            r_din <= '0;
        else if (BRAM_en)
            r_din <= r_mem[w_host_idx];
    end

    assign w_avail   = cmd_wr_ptr - r_rd_ptr;
    assign w_hdr_cnt = r_b_data[30:28];
    assign w_over    = w_hdr_cnt > MAX_N;
    assign w_dec_n   = w_over ? MAX_N : w_hdr_cnt;
    assign w_chk_n   = (r_state == S_HDR) ? w_dec_n : r_nops;
    assign w_enough  = {1'b0, w_avail} >= ((ADDR_W+1)'(w_chk_n) + (ADDR_W+1)'(1));
    assign w_last_op = (r_k == r_nops - 3'd1);
    assign w_accept  = (r_state == S_VALID) && cmd_ready;

    always_ff @(posedge BRAM_clk or negedge BRAM_rst_n) begin
        if (!BRAM_rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // The fetch offset selects which ring word lands in r_b_data for the next state.
    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no latch is inferred.
        w_next      = r_state;
        w_fetch_off = '0;
        case (r_state)
            S_IDLE: begin
                if (w_avail != '0)
                    w_next = S_HDR;
            end
            S_HDR: begin
                w_fetch_off = ADDR_W'(1);
                if (!w_enough)
                    w_next = S_WAIT;
                else if (w_dec_n == 3'd0)
                    w_next = S_VALID;
                else
                    w_next = S_OPS;
            end
            S_WAIT: begin
                w_fetch_off = ADDR_W'(1);
                if (w_enough)
                    w_next = S_OPS;
            end
            S_OPS: begin
                w_fetch_off = ADDR_W'(r_k) + ADDR_W'(2);
                if (w_last_op)
                    w_next = S_VALID;
            end
            S_VALID: begin
                if (cmd_ready)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_fetch_addr = r_rd_ptr + w_fetch_off;

    always_ff @(posedge BRAM_clk or negedge BRAM_rst_n) begin
        if (!BRAM_rst_n) begin
            r_rd_ptr <= '0;
            r_hdr    <= '0;
            r_nops   <= '0;
            r_k      <= '0;
            r_ops    <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_HDR: begin
                    r_hdr  <= r_b_data;
                    r_nops <= w_dec_n;
                    r_k    <= '0;
                    if (w_over)
                        r_err <= 1'b1;
                end
                S_OPS: begin
                    r_ops[32*r_k +: 32] <= r_b_data;
                    r_k                 <= r_k + 3'd1;
                end
                S_VALID: begin
                    if (cmd_ready) begin
                        r_rd_ptr <= r_rd_ptr + ADDR_W'(r_nops) + ADDR_W'(1);
                        r_ops    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CMD_STATS_EN
    logic [15:0] r_count;

    always_ff @(posedge BRAM_clk or negedge BRAM_rst_n) begin
        if (!BRAM_rst_n)
            r_count <= '0;
        else if (w_accept)
            r_count <= r_count + 16'd1;
    end

    assign cmd_count = r_count;
`else
    assign cmd_count = '0;
`endif

    assign BRAM_din   = r_din;
    assign cmd_rd_ptr = r_rd_ptr;
    assign cmd_valid  = (r_state == S_VALID);
    assign cmd_hdr    = r_hdr;
    assign cmd_nops   = r_nops;
    assign cmd_ops    = r_ops;
    assign cmd_err    = r_err;

endmodule

// File: tb/tb_cmd_ring_bram.sv
// Randomised bench for cmd_ring_bram against a ring/queue reference model (16-word ring).
`timescale 1ns/1ps
module tb_cmd_ring_bram;

    localparam int ADDR_W  = 4;
    localparam int NUM_OPS = 4;
    localparam int DEPTH   = 16;

    logic                  BRAM_clk = 1'b0;
    logic                  BRAM_rst_n;
    logic                  BRAM_en;
    logic [0:3]            BRAM_wen;
    logic [0:31]           BRAM_addr;
    logic [0:31]           BRAM_dout;
    logic [0:31]           BRAM_din;
    logic [ADDR_W-1:0]     cmd_wr_ptr;
    logic [ADDR_W-1:0]     cmd_rd_ptr;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [31:0]           cmd_hdr;
    logic [2:0]            cmd_nops;
    logic [32*NUM_OPS-1:0] cmd_ops;
    logic                  cmd_err;
    logic [15:0]           cmd_count;

    cmd_ring_bram #(.ADDR_W(ADDR_W), .NUM_OPS(NUM_OPS)) dut (
        .BRAM_clk   (BRAM_clk),
        .BRAM_rst_n (BRAM_rst_n),
        .BRAM_en    (BRAM_en),
        .BRAM_wen   (BRAM_wen),
        .BRAM_addr  (BRAM_addr),
        .BRAM_dout  (BRAM_dout),
        .BRAM_din   (BRAM_din),
        .cmd_wr_ptr (cmd_wr_ptr),
        .cmd_rd_ptr (cmd_rd_ptr),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_hdr    (cmd_hdr),
        .cmd_nops   (cmd_nops),
        .cmd_ops    (cmd_ops),
        .cmd_err    (cmd_err),
        .cmd_count  (cmd_count)
    );

    always #5 BRAM_clk = ~BRAM_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [31:0] m_mem [DEPTH];
    int          m_wp, m_rp;
    logic        m_err;
    logic [15:0] m_count;
    logic [31:0] c_hdr;
    logic [31:0] c_ops [NUM_OPS];
    int          c_n;

    logic [31:0] rd_word;
    int          lat, seen;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int clamp_n(input logic [31:0] hdr);
        int cnt;
        cnt = int'((hdr >> 28) & 32'd7);
        return (cnt > NUM_OPS) ? NUM_OPS : cnt;
    endfunction

    task automatic host_write(input int idx, input logic [0:3] wen, input logic [31:0] data);
        logic [31:0] mask;
        mask = {{8{wen[0]}}, {8{wen[1]}}, {8{wen[2]}}, {8{wen[3]}}};
        BRAM_en   = 1'b1;
        BRAM_wen  = wen;
        BRAM_addr = 32'(idx * 4);
        BRAM_dout = data;
        @(posedge BRAM_clk); #1;
        BRAM_en  = 1'b0;
        BRAM_wen = 4'b0000;
        m_mem[idx] = (m_mem[idx] & ~mask) | (data & mask);
    endtask

    task automatic host_read(input int idx, output logic [31:0] data);
        BRAM_en   = 1'b1;
        BRAM_wen  = 4'b0000;
        BRAM_addr = 32'(idx * 4);
        @(posedge BRAM_clk); #1;
        BRAM_en = 1'b0;
        data    = BRAM_din;
    endtask

    // Producer writes header and clamped operand count into the ring at the model write index.
    task automatic load_cmd(input logic [31:0] hdr);
        c_hdr = hdr;
        c_n   = clamp_n(hdr);
        host_write(m_wp, 4'b1111, hdr);
        for (int k = 0; k < c_n; k++)
            host_write((m_wp + 1 + k) % DEPTH, 4'b1111, c_ops[k]);
        m_wp = (m_wp + 1 + c_n) % DEPTH;
    endtask

    task automatic wait_valid(output int l);
        l = 0;
        while (cmd_valid !== 1'b1 && l < 60) begin
            @(posedge BRAM_clk); #1;
            l++;
        end
        if (cmd_valid !== 1'b1)
            check("valid_timeout", {127'b0, cmd_valid}, 128'd1);
    endtask

    task automatic run_cmd(input string tag, input int exp_lat, input int stall, output int l);
        logic [127:0] exp_ops;
        wait_valid(l);
        if (exp_lat >= 0)
            check({tag, "_lat"}, 128'(l), 128'(exp_lat));
        exp_ops = '0;
        for (int k = 0; k < c_n; k++)
            exp_ops[32*k +: 32] = c_ops[k];
        if (int'((c_hdr >> 28) & 32'd7) > NUM_OPS)
            m_err = 1'b1;
        check({tag, "_hdr"},  128'(cmd_hdr),  128'(c_hdr));
        check({tag, "_nops"}, 128'(cmd_nops), 128'(c_n));
        check({tag, "_ops"},  cmd_ops,        exp_ops);
        check({tag, "_err"},  128'(cmd_err),  128'(m_err));
        for (int s = 0; s < stall; s++) begin
            @(posedge BRAM_clk); #1;
            check({tag, "_stall"}, {cmd_valid, cmd_hdr, cmd_ops[94:0]},
                  {1'b1, c_hdr, exp_ops[94:0]});
        end
        cmd_ready = 1'b1;
        @(posedge BRAM_clk); #1;
        cmd_ready = 1'b0;
        m_rp = (m_rp + 1 + c_n) % DEPTH;
`ifdef CMD_STATS_EN
        m_count = m_count + 16'd1;
`endif
        check({tag, "_rdptr"}, 128'(cmd_rd_ptr), 128'(m_rp));
        check({tag, "_count"}, 128'(cmd_count),  128'(m_count));
        check({tag, "_drop"},  128'(cmd_valid),  128'd0);
    endtask

    task automatic random_ops();
        for (int k = 0; k < NUM_OPS; k++)
            c_ops[k] = $urandom;
    endtask

    initial begin
        BRAM_rst_n = 1'b0;
        BRAM_en    = 1'b0;
        BRAM_wen   = 4'b0000;
        BRAM_addr  = '0;
        BRAM_dout  = '0;
        cmd_wr_ptr = '0;
        cmd_ready  = 1'b0;
        m_wp = 0; m_rp = 0; m_err = 1'b0; m_count = '0;
        repeat (3) @(posedge BRAM_clk);
        #1 BRAM_rst_n = 1'b1;
        #1;
        check("rst_valid", 128'(cmd_valid),  128'd0);
        check("rst_rdptr", 128'(cmd_rd_ptr), 128'd0);
        check("rst_din",   128'(BRAM_din),   128'd0);
        check("rst_err",   128'(cmd_err),    128'd0);
        check("rst_count", 128'(cmd_count),  128'd0);
        @(posedge BRAM_clk); #1;

        // Byte-lane write, MSB lane only
        host_write(4, 4'b1111, 32'h0);
        host_write(4, 4'b1000, 32'hAABBCCDD);
        host_read(4, rd_word);
        check("byte_we", 128'(rd_word), 128'h AA000000);

        // Fill ring fully, then random partial writes with readback
        for (int i = 0; i < DEPTH; i++)
            host_write(i, 4'b1111, $urandom);
        for (int i = 0; i < 10; i++) begin
            int idx;
            idx = int'($urandom_range(0, DEPTH - 1));
            host_write(idx, 4'($urandom), $urandom);
            host_read(idx, rd_word);
            check("host_rw", 128'(rd_word), 128'(m_mem[idx]));
        end

        // Simple command
        c_ops[0] = 32'h3F800000; c_ops[1] = 32'h0; c_ops[2] = 32'h0; c_ops[3] = 32'h0;
        load_cmd(32'hB0000304);
        cmd_wr_ptr = ADDR_W'(m_wp);
        run_cmd("simple", 5, 2, lat);

        // Two 4-operand fillers bring the read index to 14
        for (int i = 0; i < 2; i++) begin
            random_ops();
            load_cmd(32'h40000000 | ($urandom & 32'h0FFFFFFF));
            cmd_wr_ptr = ADDR_W'(m_wp);
            run_cmd("fill", 6, int'($urandom_range(0, 3)), lat);
        end

        // Wrap across the end of the ring
        random_ops();
        load_cmd(32'hB0000000);
        cmd_wr_ptr = ADDR_W'(m_wp);
        run_cmd("wrap", 5, 0, lat);

        // Partial: only header + 1 operand published at first
        random_ops();
        load_cmd(32'h30000000 | ($urandom & 32'h0FFFFFFF));
        cmd_wr_ptr = ADDR_W'((m_rp + 2) % DEPTH);
        seen = 0;
        repeat (20) begin
            @(posedge BRAM_clk); #1;
            if (cmd_valid === 1'b1)
                seen++;
        end
        check("partial_hold", 128'(seen), 128'd0);
        cmd_wr_ptr = ADDR_W'(m_wp);
        run_cmd("partial", -1, 1, lat);
        check("partial_lat", 128'(lat >= 3 && lat <= 4), 128'd1);

        // Overcount header clamps and sets the sticky error
        random_ops();
        load_cmd(32'hF0000000);
        cmd_wr_ptr = ADDR_W'(m_wp);
        run_cmd("over", 6, 1, lat);

        // Randomised command stream
        for (int i = 0; i < 30; i++) begin
            logic [31:0] h;
            h = $urandom;
            h[30:28] = 3'($urandom_range(0, 7));
            random_ops();
            load_cmd(h);
            cmd_wr_ptr = ADDR_W'(m_wp);
            run_cmd("rnd", clamp_n(h) + 2, int'($urandom_range(0, 3)), lat);
        end

        // Reset in the middle of a fetch aborts the command
        random_ops();
        load_cmd(32'h40000000);
        cmd_wr_ptr = ADDR_W'(m_wp);
        repeat (3) @(posedge BRAM_clk);
        #1 BRAM_rst_n = 1'b0;
        #1;
        check("midrst_valid", 128'(cmd_valid),  128'd0);
        check("midrst_rdptr", 128'(cmd_rd_ptr), 128'd0);
        check("midrst_count", 128'(cmd_count),  128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
